// File: rtl/puf_uart_tx_fifo_if.sv
// Byte-stream valid/ready bundle feeding the buffered UART transmitter.
// The master drives data/valid; the slave answers with ready.
interface puf_uart_tx_fifo_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/puf_uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO in front of a start/data/[parity]/stop serialiser.
// Define PUF_UART_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module puf_uart_tx_fifo #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_AW    = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    puf_uart_tx_fifo_if.slave    in_bus,
    output logic                 tx,
    output logic                 busy,
    output logic [FIFO_AW:0]     fifo_count
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    // Out-of-range configurations elaborate this marker block so they are easy to spot.
    if (BAUD_DIV < 2 || BAUD_DIV > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_illegal_config
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic [FIFO_AW:0]   count_next;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    state_t             state_reg;
    state_t             state_next;
    logic [15:0]        baud_reg;
    logic [15:0]        baud_next;
    logic [2:0]         bit_reg;
    logic [2:0]         bit_next;
    logic [7:0]         shift_reg;
    logic [7:0]         shift_next;
    logic               tx_reg;
    logic               tx_next;
    logic               bit_end;
`ifdef PUF_UART_PARITY_EN
    logic               par_reg;
    logic               par_next;
`endif

    // Ready comes from the registered count only, so a full FIFO never accepts on a pop cycle.
    assign in_bus.ready = !rst && (count_reg != DEPTH_L);
    assign push         = in_bus.valid && in_bus.ready;
    assign head         = mem[rd_ptr_reg];
    assign bit_end      = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_bus.data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // tx_next is derived from the current state, so the line lags the state by one clock.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = 1'b1;
        pop        = 1'b0;
`ifdef PUF_UART_PARITY_EN
        par_next   = par_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    shift_next = head;
`ifdef PUF_UART_PARITY_EN
                    par_next   = (^head) ^ 1'(PARITY_ODD);
`endif
                    state_next = S_START;
                    baud_next  = '0;
                end
            end
            S_START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    state_next = S_DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            S_DATA: begin
                tx_next = shift_reg[0];
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    baud_next  = '0;
                    if (bit_reg == 3'd7) begin
                        bit_next = '0;
`ifdef PUF_UART_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
`ifdef PUF_UART_PARITY_EN
            S_PARITY: begin
                tx_next = par_reg;
                if (bit_end) begin
                    state_next = S_STOP;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
`endif
            S_STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_reg == STOP_LAST) begin
                        bit_next = '0;
                        // Chain straight into the next start bit when more bytes are queued.
                        if (count_reg != '0) begin
                            pop        = 1'b1;
                            shift_next = head;
`ifdef PUF_UART_PARITY_EN
                            par_next   = (^head) ^ 1'(PARITY_ODD);
`endif
                            state_next = S_START;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                baud_next  = '0;
                bit_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
`ifdef PUF_UART_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
`ifdef PUF_UART_PARITY_EN
            par_reg   <= par_next;
`endif
        end
    end

    assign tx         = tx_reg;
    assign busy       = (state_reg != S_IDLE) || (count_reg != '0);
    assign fifo_count = count_reg;

endmodule
